// File: rtl/qsort_host.sv
// qsort_host: host-side sequencer for an external word sorter.
//   Collects N words from an upstream valid/ready stream, writes them into
//   the sorter, pulses s_init, waits for s_qcomp (bounded by TMO cycles),
//   then drains the sorted words through a one-word output register while
//   checking that they arrive in non-decreasing unsigned order.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle job request (ignored unless idle)
//   din/din_valid/din_ready   upstream words
//   dout/dout_valid/dout_ready sorted words out
//   s_xin/s_write/s_init      sorter write data, write strobe, start pulse
//   s_qcomp                   sorter completion flag
//   s_read/s_xout             sorter read strobe, read data (one cycle later)
//   busy/done/sorted_ok/timeout job status
module qsort_host #(
   parameter int N   = 8,
   parameter int TMO = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [31:0] dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [31:0] s_xin,
   output logic        s_write,
   output logic        s_init,
   input  logic        s_qcomp,
   output logic        s_read,
   input  logic [31:0] s_xout,
   output logic        busy,
   output logic        done,
   output logic        sorted_ok,
   output logic        timeout
);

   localparam int MAXV = (N > TMO) ? N : TMO;
   localparam int CW   = $clog2(MAXV + 1);
   localparam logic [CW-1:0] N_C   = CW'(N);
   localparam logic [CW-1:0] N_M1  = CW'(N - 1);
   localparam logic [CW-1:0] TMO_C = CW'(TMO);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   state_t state_q, state_d;

   // cnt: words loaded in LOAD, cycles waited in WAIT
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;    // sorter reads issued
   logic [CW-1:0] out_cnt_q, out_cnt_d;  // output handshakes completed
   logic          pend_q, pend_d;        // read issued last cycle, data on s_xout now
   logic          dv_q, dv_d;
   logic [31:0]   dout_q, dout_d;
   logic [31:0]   prev_q, prev_d;
   logic          ok_q, ok_d;
   logic          tmo_q, tmo_d;

   logic rd_go;
   logic hs;
   logic last_wait;

   assign hs        = dv_q & dout_ready;
   assign last_wait = ((cnt_q + 1'b1) == TMO_C);
   // Only one read in flight: the slot is free when nothing is pending and
   // the output register is empty or being emptied this cycle.
   assign rd_go = (state_q == S_DRAIN) && (rd_cnt_q < N_C) && !pend_q &&
                  (!dv_q || dout_ready);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  if (din_valid && cnt_q == N_M1) state_d = S_KICK;
         S_KICK:  state_d = S_WAIT;
         S_WAIT: begin
            if (s_qcomp)        state_d = S_DRAIN;
            else if (last_wait) state_d = S_DONE;
         end
         S_DRAIN: if (hs && out_cnt_q == N_M1) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      cnt_d     = cnt_q;
      rd_cnt_d  = rd_cnt_q;
      out_cnt_d = out_cnt_q;
      pend_d    = 1'b0;
      dv_d      = 1'b0;
      dout_d    = '0;
      prev_d    = prev_q;
      ok_d      = ok_q;
      tmo_d     = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d = '0;
               ok_d  = 1'b0;
               tmo_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (din_valid) cnt_d = (cnt_q == N_M1) ? '0 : cnt_q + 1'b1;
         end
         S_KICK: begin
            cnt_d     = '0;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (s_qcomp) begin
               ok_d   = 1'b1;
               prev_d = '0;
            end else if (last_wait) begin
               tmo_d = 1'b1;
               ok_d  = 1'b0;
            end
         end
         S_DRAIN: begin
            dv_d   = dv_q;
            dout_d = dout_q;
            if (rd_go) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               pend_d   = 1'b1;
            end
            if (hs) begin
               dv_d      = 1'b0;
               out_cnt_d = out_cnt_q + 1'b1;
            end
            // A pending read implies the register was freed when it was issued.
            if (pend_q) begin
               dout_d = s_xout;
               dv_d   = 1'b1;
               prev_d = s_xout;
               // rd_cnt_q counts this word too, so >=2 means word index >= 1
               if (rd_cnt_q >= CW'(2) && s_xout < prev_q) ok_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         rd_cnt_q  <= '0;
         out_cnt_q <= '0;
         pend_q    <= 1'b0;
         dv_q      <= 1'b0;
         dout_q    <= '0;
         prev_q    <= '0;
         ok_q      <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         out_cnt_q <= out_cnt_d;
         pend_q    <= pend_d;
         dv_q      <= dv_d;
         dout_q    <= dout_d;
         prev_q    <= prev_d;
         ok_q      <= ok_d;
         tmo_q     <= tmo_d;
      end
   end

   // Output decode
   always_comb begin
      din_ready  = (state_q == S_LOAD);
      s_write    = (state_q == S_LOAD) && din_valid;
      s_xin      = (state_q == S_LOAD) ? din : '0;
      s_init     = (state_q == S_KICK);
      s_read     = rd_go;
      busy       = (state_q == S_LOAD) || (state_q == S_KICK) ||
                   (state_q == S_WAIT) || (state_q == S_DRAIN);
      done       = (state_q == S_DONE);
      dout       = dout_q;
      dout_valid = dv_q;
      sorted_ok  = ok_q;
      timeout    = tmo_q;
   end

endmodule
